// File: rtl/ahb_output_stage_arb.sv
// AHB bus-matrix output stage with built-in arbiter.
// Routes one of NUM_PORTS input-stage ports onto a shared slave port. Arbitration is
// round-robin (ARB_MODE = 0) or fixed priority with port 0 highest (ARB_MODE = 1).
// Defined-length bursts are kept on one port by a beat counter, and locked sequences
// keep their grant across HSEL gaps.
module ahb_output_stage_arb #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned PORT_W     = 1,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ARB_MODE   = 0
) (
  input  logic                            HCLK,
  input  logic                            HRESET,
  input  logic [NUM_PORTS-1:0]            sel_op,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_op,
  input  logic [NUM_PORTS*2-1:0]          trans_op,
  input  logic [NUM_PORTS-1:0]            write_op,
  input  logic [NUM_PORTS*3-1:0]          size_op,
  input  logic [NUM_PORTS*3-1:0]          burst_op,
  input  logic [NUM_PORTS*4-1:0]          prot_op,
  input  logic [NUM_PORTS*4-1:0]          master_op,
  input  logic [NUM_PORTS-1:0]            mastlock_op,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_op,
  input  logic [NUM_PORTS-1:0]            held_tran_op,
  input  logic                            HREADYOUTM,
  output logic [NUM_PORTS-1:0]            active_op,
  output logic                            HSELM,
  output logic [ADDR_WIDTH-1:0]           HADDRM,
  output logic [1:0]                      HTRANSM,
  output logic                            HWRITEM,
  output logic [2:0]                      HSIZEM,
  output logic [2:0]                      HBURSTM,
  output logic [3:0]                      HPROTM,
  output logic [3:0]                      HMASTERM,
  output logic                            HMASTLOCKM,
  output logic                            HREADYMUXM,
  output logic [DATA_WIDTH-1:0]           HWDATAM
);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;

  localparam logic [2:0] BurstWrap4  = 3'b010;
  localparam logic [2:0] BurstIncr4  = 3'b011;
  localparam logic [2:0] BurstWrap8  = 3'b100;
  localparam logic [2:0] BurstIncr8  = 3'b101;
  localparam logic [2:0] BurstWrap16 = 3'b110;
  localparam logic [2:0] BurstIncr16 = 3'b111;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] rr_mask;
  logic [NUM_PORTS-1:0] req_hi;
  logic                 any_req;
  logic [PORT_W-1:0]    win_lo;
  logic [PORT_W-1:0]    win_hi;
  logic                 found_lo;
  logic                 found_hi;
  logic [PORT_W-1:0]    winner;
  logic                 hold;
  logic                 nonseq_acc;
  logic                 seq_acc;
  logic                 owner_idle;

  logic [PORT_W-1:0] addr_in_port_q, addr_in_port_d;
  logic              no_port_q, no_port_d;
  logic [PORT_W-1:0] data_in_port_q;
  logic              slave_sel_q;
  logic              hsel_lock_q, hsel_lock_d;
  logic [3:0]        beat_cnt_q, beat_cnt_d;
  logic [PORT_W-1:0] last_grant_q, last_grant_d;

  assign req     = held_tran_op & sel_op;
  assign any_req = |req;
  assign req_hi  = req & rr_mask;

  // Ports strictly above the last grant get first pick in round-robin.
  always_comb begin
    rr_mask = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      rr_mask[i] = (PORT_W'(i) > last_grant_q);
    end
  end

  // Winner selection: lowest-index requester overall, or above the last grant first.
  always_comb begin
    win_lo   = '0;
    win_hi   = '0;
    found_lo = 1'b0;
    found_hi = 1'b0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (req[i] && !found_lo) begin
        win_lo   = PORT_W'(i);
        found_lo = 1'b1;
      end
      if (req_hi[i] && !found_hi) begin
        win_hi   = PORT_W'(i);
        found_hi = 1'b1;
      end
    end
    if (ARB_MODE == 1) begin
      winner = win_lo;
    end else begin
      winner = found_hi ? win_hi : win_lo;
    end
  end

  // Address/control mux driven from the registered address-phase owner.
  always_comb begin
    active_op  = '0;
    HSELM      = 1'b0;
    HADDRM     = '0;
    HTRANSM    = TransIdle;
    HWRITEM    = 1'b0;
    HSIZEM     = '0;
    HBURSTM    = '0;
    HPROTM     = '0;
    HMASTERM   = '0;
    HMASTLOCKM = 1'b0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (!no_port_q && (addr_in_port_q == PORT_W'(i))) begin
        active_op[i] = 1'b1;
        HSELM        = sel_op[i];
        HADDRM       = addr_op[i*ADDR_WIDTH +: ADDR_WIDTH];
        HTRANSM      = trans_op[i*2 +: 2];
        HWRITEM      = write_op[i];
        HSIZEM       = size_op[i*3 +: 3];
        HBURSTM      = burst_op[i*3 +: 3];
        HPROTM       = prot_op[i*4 +: 4];
        HMASTERM     = master_op[i*4 +: 4];
        HMASTLOCKM   = mastlock_op[i];
      end
    end
  end

  // Write-data mux follows the data-phase owner, one transfer behind the address mux.
  always_comb begin
    HWDATAM = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (data_in_port_q == PORT_W'(i)) begin
        HWDATAM = wdata_op[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign HREADYMUXM = slave_sel_q ? HREADYOUTM : 1'b1;

  assign nonseq_acc = HSELM && (HTRANSM == TransNonseq);
  assign seq_acc    = HSELM && (HTRANSM == TransSeq);
  assign owner_idle = !no_port_q && (HTRANSM == TransIdle);

  // Beats left in a defined-length burst after the beat currently on the bus.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (nonseq_acc) begin
      unique case (HBURSTM)
        BurstWrap4, BurstIncr4:   beat_cnt_d = 4'd3;
        BurstWrap8, BurstIncr8:   beat_cnt_d = 4'd7;
        BurstWrap16, BurstIncr16: beat_cnt_d = 4'd15;
        default:                  beat_cnt_d = 4'd0;
      endcase
    end else if (seq_acc && (beat_cnt_q != 4'd0)) begin
      beat_cnt_d = beat_cnt_q - 4'd1;
    end else if (owner_idle) begin
      beat_cnt_d = 4'd0;
    end
  end

  // Post-beat count is used so the first (NONSEQ) beat of a burst already blocks
  // re-arbitration; SEQ/BUSY and an active lock also keep the current owner.
  assign hold = (beat_cnt_d != 4'd0) || HTRANSM[0] || (HMASTLOCKM && (HSELM || hsel_lock_q));

  // Next owner and lock tracking.
  always_comb begin
    addr_in_port_d = addr_in_port_q;
    no_port_d      = no_port_q;
    last_grant_d   = last_grant_q;
    if (!hold) begin
      if (any_req) begin
        no_port_d      = 1'b0;
        addr_in_port_d = winner;
        last_grant_d   = winner;
      end else begin
        no_port_d = 1'b1;
      end
    end
    if (HSELM && HTRANSM[1] && HMASTLOCKM) begin
      hsel_lock_d = 1'b1;
    end else if (!HMASTLOCKM) begin
      hsel_lock_d = 1'b0;
    end else begin
      hsel_lock_d = hsel_lock_q;
    end
  end

  // All state advances only on a ready cycle; wait states freeze everything.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_in_port_q <= '0;
      no_port_q      <= 1'b1;
      data_in_port_q <= '0;
      slave_sel_q    <= 1'b0;
      hsel_lock_q    <= 1'b0;
      beat_cnt_q     <= 4'd0;
      last_grant_q   <= PORT_W'(NUM_PORTS - 1);
    end else if (HREADYMUXM) begin
      addr_in_port_q <= addr_in_port_d;
      no_port_q      <= no_port_d;
      data_in_port_q <= addr_in_port_q;
      slave_sel_q    <= HSELM;
      hsel_lock_q    <= hsel_lock_d;
      beat_cnt_q     <= beat_cnt_d;
      last_grant_q   <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_ahb_output_stage_arb.sv
// Bench for ahb_output_stage_arb: a round-robin and a fixed-priority instance share the
// same port stimulus; expected owner/trans/ready/data are queued and checked each cycle.
module tb_ahb_output_stage_arb;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic               HCLK = 1'b0;
  logic               HRESET;
  logic [NP-1:0]      sel_op, write_op, mastlock_op, held_tran_op;
  logic [NP*AW-1:0]   addr_op;
  logic [NP*2-1:0]    trans_op;
  logic [NP*3-1:0]    size_op, burst_op;
  logic [NP*4-1:0]    prot_op, master_op;
  logic [NP*DW-1:0]   wdata_op;
  logic               HREADYOUTM;

  logic [NP-1:0] active_rr, active_fp;
  logic          hsel_rr, hsel_fp, hwrite_rr, hwrite_fp, hlock_rr, hlock_fp;
  logic          hready_rr, hready_fp;
  logic [AW-1:0] haddr_rr, haddr_fp;
  logic [1:0]    htrans_rr, htrans_fp;
  logic [2:0]    hsize_rr, hsize_fp, hburst_rr, hburst_fp;
  logic [3:0]    hprot_rr, hprot_fp, hmaster_rr, hmaster_fp;
  logic [DW-1:0] hwdata_rr, hwdata_fp;

  typedef struct packed {
    logic [NP-1:0] act;
    logic [1:0]    trans;
    logic          rdy;
    logic          chk_wd;
    logic [DW-1:0] wd;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;

  ahb_output_stage_arb #(
    .NUM_PORTS(NP), .PORT_W(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(0)
  ) u_rr (
    .HCLK(HCLK), .HRESET(HRESET), .sel_op(sel_op), .addr_op(addr_op), .trans_op(trans_op),
    .write_op(write_op), .size_op(size_op), .burst_op(burst_op), .prot_op(prot_op),
    .master_op(master_op), .mastlock_op(mastlock_op), .wdata_op(wdata_op),
    .held_tran_op(held_tran_op), .HREADYOUTM(HREADYOUTM), .active_op(active_rr),
    .HSELM(hsel_rr), .HADDRM(haddr_rr), .HTRANSM(htrans_rr), .HWRITEM(hwrite_rr),
    .HSIZEM(hsize_rr), .HBURSTM(hburst_rr), .HPROTM(hprot_rr), .HMASTERM(hmaster_rr),
    .HMASTLOCKM(hlock_rr), .HREADYMUXM(hready_rr), .HWDATAM(hwdata_rr)
  );

  ahb_output_stage_arb #(
    .NUM_PORTS(NP), .PORT_W(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(1)
  ) u_fp (
    .HCLK(HCLK), .HRESET(HRESET), .sel_op(sel_op), .addr_op(addr_op), .trans_op(trans_op),
    .write_op(write_op), .size_op(size_op), .burst_op(burst_op), .prot_op(prot_op),
    .master_op(master_op), .mastlock_op(mastlock_op), .wdata_op(wdata_op),
    .held_tran_op(held_tran_op), .HREADYOUTM(HREADYOUTM), .active_op(active_fp),
    .HSELM(hsel_fp), .HADDRM(haddr_fp), .HTRANSM(htrans_fp), .HWRITEM(hwrite_fp),
    .HSIZEM(hsize_fp), .HBURSTM(hburst_fp), .HPROTM(hprot_fp), .HMASTERM(hmaster_fp),
    .HMASTLOCKM(hlock_fp), .HREADYMUXM(hready_fp), .HWDATAM(hwdata_fp)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
    $fatal(1);
  end

  function automatic logic [AW-1:0] addr_of(input int p);
    return 32'h4000_0000 + 32'(p) * 32'h100;
  endfunction

  function automatic logic [DW-1:0] wdata_of(input int p);
    return 32'hD0D0_0000 + 32'(p);
  endfunction

  task automatic set_port(input int p, input logic sel, input logic held,
                          input logic [1:0] tr, input logic [2:0] bu, input logic lk,
                          input logic [AW-1:0] ad);
    sel_op[p]            = sel;
    held_tran_op[p]      = held;
    trans_op[p*2 +: 2]   = tr;
    burst_op[p*3 +: 3]   = bu;
    mastlock_op[p]       = lk;
    addr_op[p*AW +: AW]  = ad;
  endtask

  task automatic clear_inputs();
    sel_op = '0; write_op = '0; mastlock_op = '0; held_tran_op = '0;
    addr_op = '0; trans_op = '0; size_op = '0; burst_op = '0;
    prot_op = '0; master_op = '0; HREADYOUTM = 1'b1;
    for (int i = 0; i < NP; i++) wdata_op[i*DW +: DW] = wdata_of(i);
  endtask

  // Leaves the bench at posedge+1 with reset just released.
  task automatic do_reset();
    HRESET = 1'b1;
    clear_inputs();
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    clear_inputs();
    @(negedge HCLK);
    n_vec++; if (active_rr !== 4'b0000) begin n_err++;
      $display("FAIL reset_active got=%b exp=0000", active_rr); end
    n_vec++; if (htrans_rr !== 2'b00) begin n_err++;
      $display("FAIL reset_htrans got=%b exp=00", htrans_rr); end
    n_vec++; if (hsel_rr !== 1'b0) begin n_err++;
      $display("FAIL reset_hsel got=%b exp=0", hsel_rr); end
    n_vec++; if (haddr_rr !== '0) begin n_err++;
      $display("FAIL reset_haddr got=%h exp=0", haddr_rr); end
    n_vec++; if (hready_rr !== 1'b1) begin n_err++;
      $display("FAIL reset_hready got=%b exp=1", hready_rr); end
    n_vec++; if (hwdata_rr !== wdata_of(0)) begin n_err++;
      $display("FAIL reset_hwdata got=%h exp=%h", hwdata_rr, wdata_of(0)); end
    n_vec++; if (u_rr.no_port_q !== 1'b1) begin n_err++;
      $display("FAIL reset_no_port got=%b exp=1", u_rr.no_port_q); end
    n_vec++; if (active_fp !== 4'b0000) begin n_err++;
      $display("FAIL reset_active_fp got=%b exp=0000", active_fp); end
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    n_vec++; if (active_rr !== 4'b0000 || u_rr.no_port_q !== 1'b1) begin n_err++;
      $display("FAIL idle_no_req active=%b no_port=%b exp=0000/1", active_rr, u_rr.no_port_q);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int p = 0; p < NP; p++) set_port(p, 1'b1, 1'b1, 2'b10, 3'b000, 1'b0, addr_of(p));
    for (int k = 0; k < 8; k++) begin
      e.act = 4'(1 << (k % NP)); e.trans = 2'b10; e.rdy = 1'b1; e.chk_wd = 1'b1;
      e.wd  = wdata_of((k == 0) ? 0 : (k - 1) % NP);
      sb.push_back(e);
      @(posedge HCLK); #1;
      if (sb.size() == 0) begin n_vec++; n_err++; $display("FAIL rr_sb_empty k=%0d", k); end
      else begin
        e = sb.pop_front();
        n_vec++; if (active_rr !== e.act) begin n_err++;
          $display("FAIL rr_active k=%0d got=%b exp=%b", k, active_rr, e.act); end
        n_vec++; if (haddr_rr !== addr_of(k % NP)) begin n_err++;
          $display("FAIL rr_haddr k=%0d got=%h exp=%h", k, haddr_rr, addr_of(k % NP)); end
        n_vec++; if (hwdata_rr !== e.wd) begin n_err++;
          $display("FAIL rr_hwdata k=%0d got=%h exp=%h", k, hwdata_rr, e.wd); end
        n_vec++; if (htrans_rr !== e.trans || hready_rr !== e.rdy) begin n_err++;
          $display("FAIL rr_ctrl k=%0d got=%b/%b exp=%b/%b", k, htrans_rr, hready_rr,
                   e.trans, e.rdy); end
      end
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    set_port(1, 1'b1, 1'b1, 2'b10, 3'b000, 1'b0, addr_of(1));
    set_port(3, 1'b1, 1'b1, 2'b10, 3'b000, 1'b0, addr_of(3));
    for (int k = 0; k < 7; k++) begin
      if (k == 4) held_tran_op[1] = 1'b0;
      e.act = (k < 4) ? 4'b0010 : 4'b1000; e.trans = 2'b10; e.rdy = 1'b1;
      e.chk_wd = 1'b0; e.wd = '0;
      sb.push_back(e);
      @(posedge HCLK); #1;
      if (sb.size() == 0) begin n_vec++; n_err++; $display("FAIL fp_sb_empty k=%0d", k); end
      else begin
        e = sb.pop_front();
        n_vec++; if (active_fp !== e.act) begin n_err++;
          $display("FAIL fp_active k=%0d got=%b exp=%b", k, active_fp, e.act); end
        n_vec++; if (htrans_fp !== e.trans || hready_fp !== e.rdy) begin n_err++;
          $display("FAIL fp_ctrl k=%0d got=%b/%b exp=%b/%b", k, htrans_fp, hready_fp,
                   e.trans, e.rdy); end
      end
    end
  endtask

  // Port 2 INCR4 with a two-cycle stall on beat 2; port 0 waits for the burst to end.
  task automatic test_burst_hold();
    logic [1:0] p2_tr [8] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
    int         p2_off[8] = '{0, 0, 4, 8, 8, 8, 12, 12};
    logic       p2_hd [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    logic       p0_rq [8] = '{0, 1, 1, 1, 1, 1, 1, 1};
    logic       rdy_in[8] = '{1, 1, 1, 0, 0, 1, 1, 1};
    logic [3:0] ex_act[8] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                              4'b0100, 4'b0001};
    logic [1:0] ex_tr [8] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10};
    logic       ex_rdy[8] = '{1, 1, 1, 0, 0, 1, 1, 1};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      set_port(2, 1'b1, p2_hd[k], p2_tr[k], 3'b011, 1'b0, addr_of(2) + 32'(p2_off[k]));
      set_port(0, p0_rq[k], p0_rq[k], 2'b10, 3'b000, 1'b0, addr_of(0));
      HREADYOUTM = rdy_in[k];
      e.act = ex_act[k]; e.trans = ex_tr[k]; e.rdy = ex_rdy[k]; e.chk_wd = 1'b0; e.wd = '0;
      sb.push_back(e);
      @(posedge HCLK); #1;
      if (sb.size() == 0) begin n_vec++; n_err++; $display("FAIL burst_sb_empty k=%0d", k); end
      else begin
        e = sb.pop_front();
        n_vec++; if (active_rr !== e.act) begin n_err++;
          $display("FAIL burst_active k=%0d got=%b exp=%b", k, active_rr, e.act); end
        n_vec++; if (htrans_rr !== e.trans || hready_rr !== e.rdy) begin n_err++;
          $display("FAIL burst_ctrl k=%0d got=%b/%b exp=%b/%b", k, htrans_rr, hready_rr,
                   e.trans, e.rdy); end
      end
    end
  endtask

  // Port 1 locked with HSEL low for one cycle; port 0 must wait until the lock drops.
  task automatic test_lock_hold();
    logic       p1_sel[5] = '{1, 1, 0, 1, 1};
    logic [1:0] p1_tr [5] = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b10};
    logic       p1_lk [5] = '{1, 1, 1, 1, 0};
    logic       p0_rq [5] = '{0, 1, 1, 1, 1};
    logic [3:0] ex_act[5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    logic [1:0] ex_tr [5] = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b10};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_port(1, p1_sel[k], 1'b1, p1_tr[k], 3'b000, p1_lk[k], addr_of(1));
      set_port(0, p0_rq[k], p0_rq[k], 2'b10, 3'b000, 1'b0, addr_of(0));
      e.act = ex_act[k]; e.trans = ex_tr[k]; e.rdy = 1'b1; e.chk_wd = 1'b0; e.wd = '0;
      sb.push_back(e);
      @(posedge HCLK); #1;
      if (sb.size() == 0) begin n_vec++; n_err++; $display("FAIL lock_sb_empty k=%0d", k); end
      else begin
        e = sb.pop_front();
        n_vec++; if (active_rr !== e.act) begin n_err++;
          $display("FAIL lock_active k=%0d got=%b exp=%b", k, active_rr, e.act); end
        n_vec++; if (htrans_rr !== e.trans || hready_rr !== e.rdy) begin n_err++;
          $display("FAIL lock_ctrl k=%0d got=%b/%b exp=%b/%b", k, htrans_rr, hready_rr,
                   e.trans, e.rdy); end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_port(2, 1'b1, 1'b1, 2'b10, 3'b101, 1'b0, addr_of(2));
    @(posedge HCLK); #1;
    n_vec++; if (active_rr !== 4'b0100) begin n_err++;
      $display("FAIL mid_grant got=%b exp=0100", active_rr); end
    @(posedge HCLK); #1;
    n_vec++; if (u_rr.beat_cnt_q !== 4'd7) begin n_err++;
      $display("FAIL mid_beat_load got=%0d exp=7", u_rr.beat_cnt_q); end
    set_port(2, 1'b1, 1'b1, 2'b11, 3'b101, 1'b0, addr_of(2) + 32'd4);
    @(posedge HCLK); #1;
    n_vec++; if (u_rr.beat_cnt_q !== 4'd6) begin n_err++;
      $display("FAIL mid_beat_dec got=%0d exp=6", u_rr.beat_cnt_q); end
    HREADYOUTM = 1'b0;
    HRESET     = 1'b1;
    #1;
    n_vec++; if (active_rr !== 4'b0000 || htrans_rr !== 2'b00 || hsel_rr !== 1'b0) begin
      n_err++;
      $display("FAIL mid_async_out active=%b htrans=%b hsel=%b exp=0000/00/0",
               active_rr, htrans_rr, hsel_rr);
    end
    n_vec++; if (hready_rr !== 1'b1 || u_rr.beat_cnt_q !== 4'd0) begin n_err++;
      $display("FAIL mid_async_state hready=%b beat=%0d exp=1/0", hready_rr, u_rr.beat_cnt_q);
    end
    clear_inputs();
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    n_vec++; if (u_rr.beat_cnt_q !== 4'd0 || active_rr !== 4'b0000) begin n_err++;
      $display("FAIL mid_after_release beat=%0d active=%b exp=0/0000",
               u_rr.beat_cnt_q, active_rr);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_burst_hold();
    test_lock_hold();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_output_stage_arb.md
Name: ahb_output_stage_arb

Overview:
- Parametrised successor of the two-port DMA bus-matrix output stage.
- Routes one of NUM_PORTS input-stage ports onto a shared AHB slave port.
- Contains its own arbiter, selectable as round-robin or fixed-priority.
- New behaviour: defined-length bursts (INCR4/8/16, WRAP4/8/16) are held atomically by a beat counter, and locked sequences are held across HSEL gaps.
- Sits between the input stages and each slave port of the matrix.

Parameters:
NUM_PORTS, 2, number of input ports (2..8)
PORT_W, 1, width of port index; must equal max(1, clog2(NUM_PORTS))
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, write-data width
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 highest)

Ports:
HCLK  in  1  AHB clock
HRESET  in  1  asynchronous, active-high reset
sel_op  in  NUM_PORTS  per-port HSEL
addr_op  in  NUM_PORTS*ADDR_WIDTH  per-port HADDR, port i at slice i
trans_op  in  NUM_PORTS*2  per-port HTRANS
write_op  in  NUM_PORTS  per-port HWRITE
size_op  in  NUM_PORTS*3  per-port HSIZE
burst_op  in  NUM_PORTS*3  per-port HBURST
prot_op  in  NUM_PORTS*4  per-port HPROT
master_op  in  NUM_PORTS*4  per-port HMASTER
mastlock_op  in  NUM_PORTS  per-port HMASTLOCK
wdata_op  in  NUM_PORTS*DATA_WIDTH  per-port HWDATA
held_tran_op  in  NUM_PORTS  per-port pending-transfer flag
HREADYOUTM  in  1  slave HREADYOUT
active_op  out  NUM_PORTS  one-hot: port currently owns the address phase
HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM, HMASTERM, HMASTLOCKM  out  1/ADDR_WIDTH/2/1/3/3/4/4/1  muxed address/control
HREADYMUXM  out  1  shared-slave HREADY
HWDATAM  out  DATA_WIDTH  muxed write data

Behaviour:
- Clock and reset: one clock, HCLK. Reset HRESET is asynchronous, active-high. All flops reset on posedge HRESET.
- Request: req[i] = held_tran_op[i] & sel_op[i].
- Registered state:
  - addr_in_port (PORT_W bits), reset 0.
  - no_port, reset 1.
  - data_in_port, reset 0.
  - slave_sel, reset 0.
  - hsel_lock, reset 0.
  - beat_cnt (4 bits), reset 0.
  - last_grant, reset NUM_PORTS-1.
- All registered state updates only when HREADYMUXM = 1.
- Output at reset: active_op = 0, HSELM = 0, HTRANSM = 00, all address/control = 0, HREADYMUXM = 1, HWDATAM = wdata_op slice 0.
- Address mux: combinational from addr_in_port. When no_port = 1, all address/control outputs = 0.
- active_op[i] = ~no_port & (addr_in_port == i).
- hold condition (no re-arbitration on this HREADYMUXM cycle) is true if any of:
  - (a) beat_cnt != 0;
  - (b) current port's trans is BUSY or SEQ;
  - (c) lock: HMASTLOCKM & (HSELM | hsel_lock).
- beat_cnt:
  - On an accepted NONSEQ, load 3/7/15 for burst 4/8/16 beats (WRAP or INCR); load 0 for SINGLE/INCR.
  - Decrement on each accepted SEQ.
  - An IDLE from the owner clears it (early-terminated burst).
- Arbitration, when HREADYMUXM = 1 and hold is false:
  - If no req, set no_port = 1 and keep addr_in_port.
  - Otherwise no_port = 0 and addr_in_port = winner.
  - Fixed priority: lowest-index requester wins.
  - Round-robin: first requester scanning last_grant+1 upward, with wrap.
  - last_grant updates to the winner.
  - If the current owner still requests and hold is false, round-robin still rotates; fixed priority re-evaluates.
- hsel_lock next value:
  - 1 if HSELM & HTRANSM[1] & HMASTLOCKM;
  - 0 if ~HMASTLOCKM;
  - otherwise holds.
- data phase: data_in_port <= addr_in_port; HWDATAM = wdata_op slice data_in_port.
- HREADYMUXM: slave_sel <= HSELM; HREADYMUXM = slave_sel ? HREADYOUTM : 1.
- Wait states (HREADYMUXM = 0): all grants, counters and mux selects are frozen.
- Latency: a request presented at edge n is granted on the address bus after edge n+1 (one registered arbitration cycle).
- Reset asserted mid-burst: immediate return to reset state; no beat is resumed.

Test Plan:
- Reset, no requests -> active_op = 0, HTRANSM = 00, HREADYMUXM = 1, no_port = 1.
- NUM_PORTS = 4, ARB_MODE = 0, ports 0..3 request SINGLE NONSEQ continuously, HREADYOUTM = 1 -> grants cycle 0,1,2,3,0 on successive cycles; HWDATAM follows one cycle later.
- ARB_MODE = 1, ports 1 and 3 request -> port 1 granted every cycle; port 3 granted only after port 1 drops held_tran.
- Port 2 issues INCR4 while port 0 requests -> port 2 holds 4 address beats (NONSEQ + 3 SEQ) with HREADYOUTM stalling 2 cycles on beat 2; port 0 granted on the cycle after the 4th beat.
- Port 1 locked sequence with HSEL dropped for 1 cycle mid-lock, port 0 requesting -> port 1 retains grant until mastlock_op[1] = 0.
- Assert HRESET during beat 2 of an INCR8 -> outputs return to reset values asynchronously; beat_cnt = 0 after release.
